// File: rtl/pixel_pkg.sv
// Shared types and helpers for the pixel read-modify-write writer: packed pixel
// geometry, FSM state encoding, the FIFO request record and word-merge helpers.
package pixel_pkg;

    localparam int PIX_PER_WORD = 8;
    localparam int BITS_PER_PIX = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } pixel_state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [1:0] colour;
    } pixel_req_t;

    // Row-major word address; the column contributes x / PIX_PER_WORD.
    function automatic logic [19:0] word_addr(input logic [9:0] x,
                                              input logic [8:0] y,
                                              input logic [19:0] words_per_line);
        word_addr = (20'(y) * words_per_line) + 20'(x[9:3]);
    endfunction

    function automatic logic [15:0] merge_pixel(input logic [15:0] word,
                                                input logic [2:0]  slot,
                                                input logic [1:0]  colour);
        logic [3:0]  shamt;
        logic [15:0] mask;
        shamt       = 4'(32'(slot) * BITS_PER_PIX);
        mask        = 16'h0003 << shamt;
        merge_pixel = (word & ~mask) | (16'(colour) << shamt);
    endfunction

endpackage

// File: rtl/pixel_rmw_writer_fifo.sv
// Synchronous request FIFO (power-of-two depth) with full/empty flags and
// asynchronous active-high reset of the pointers and occupancy count.
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_en;
    logic             pop_en;

    assign full    = (count_r == (AW+1)'(DEPTH));
    assign empty   = (count_r == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign head    = mem[rd_ptr_r];

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_en) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/pixel_rmw_writer.sv
// Pixel write front-end: buffers single-pixel writes and commits each into a
// packed 16-bit SRAM word by read-modify-write. Optional macro PIXEL_CLIP_EN.
module pixel_rmw_writer
    import pixel_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480
) (
    input  logic        VGA_CTRL_CLK,
    input  logic        reset,
    input  logic [9:0]  write_xCoord,
    input  logic [8:0]  write_yCoord,
    input  logic        w_en,
    input  logic [1:0]  disp_bit,
    output logic        in_ready,
    output logic [19:0] sram_addr,
    output logic        sram_rd_req,
    output logic        sram_wr_req,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    input  logic        sram_ack,
    output logic        busy,
    output logic [7:0]  drop_count
);

    localparam logic [19:0] WORDS_PER_LINE = 20'(SCREEN_W / PIX_PER_WORD);

    pixel_state_t state_r;
    pixel_req_t   push_req;
    pixel_req_t   head;
    logic         full;
    logic         empty;
    logic         in_range;
    logic         push_try;
    logic         pop;
    logic [19:0]  addr_r;
    logic [2:0]   slot_r;
    logic [1:0]   colour_r;
    logic [15:0]  merge_r;
    logic         rd_req_r;
    logic         wr_req_r;
    logic [7:0]   drop_r;

`ifdef PIXEL_CLIP_EN
    assign in_range = (write_xCoord < 10'(SCREEN_W)) & (write_yCoord < 9'(SCREEN_H));
`else
    logic [8:0] unused_screen_h;
    assign unused_screen_h = 9'(SCREEN_H);
    assign in_range        = 1'b1;
`endif

    assign push_try = w_en & in_range;
    assign pop      = (state_r == IDLE) & ~empty;
    assign push_req = '{x: write_xCoord, y: write_yCoord, colour: disp_bit};

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(pixel_req_t))
    ) u_fifo (
        .clk       (VGA_CTRL_CLK),
        .rst       (reset),
        .push      (push_try),
        .push_data (push_req),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // A pop in the same cycle never rescues a push against a full FIFO.
    always_ff @(posedge VGA_CTRL_CLK or posedge reset) begin
        if (reset) begin
            drop_r <= 8'd0;
        end else if (push_try && full && (drop_r != 8'hFF)) begin
            drop_r <= drop_r + 8'd1;
        end else begin
            drop_r <= drop_r;
        end
    end

    // Read-modify-write sequencer; request strobes are registered with the state.
    always_ff @(posedge VGA_CTRL_CLK or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            addr_r   <= 20'd0;
            slot_r   <= 3'd0;
            colour_r <= 2'd0;
            merge_r  <= 16'd0;
            rd_req_r <= 1'b0;
            wr_req_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!empty) begin
                        addr_r   <= word_addr(head.x, head.y, WORDS_PER_LINE);
                        slot_r   <= head.x[2:0];
                        colour_r <= head.colour;
                        rd_req_r <= 1'b1;
                        state_r  <= RD;
                    end
                end
                RD: begin
                    if (sram_ack) begin
                        merge_r  <= merge_pixel(sram_rdata, slot_r, colour_r);
                        rd_req_r <= 1'b0;
                        wr_req_r <= 1'b1;
                        state_r  <= WR;
                    end
                end
                WR: begin
                    if (sram_ack) begin
                        wr_req_r <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    rd_req_r <= 1'b0;
                    wr_req_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign sram_addr   = addr_r;
    assign sram_rd_req = rd_req_r;
    assign sram_wr_req = wr_req_r;
    assign sram_wdata  = merge_r;
    assign drop_count  = drop_r;
    assign in_ready    = ~full;
    assign busy        = (state_r != IDLE) | ~empty;

endmodule
